// File: rtl/spec_vacc.sv
// Vector accumulator: integrates per-channel power samples in block RAM and
// streams the finished sums out during the spectrum after each honoured new_acc.
module spec_vacc #(
  parameter int unsigned CHANNEL_ADDR = 7,
  parameter int unsigned DIN_WIDTH    = 32,
  parameter int unsigned DOUT_WIDTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync_in,
  input  logic [DIN_WIDTH-1:0]    din,
  input  logic                    din_valid,
  input  logic                    new_acc,
  output logic [DOUT_WIDTH-1:0]   dout,
  output logic [CHANNEL_ADDR-1:0] dout_chan,
  output logic                    dout_valid,
  output logic                    ovf,
  output logic                    err_align
);

  localparam int unsigned NCHAN = 2**CHANNEL_ADDR;

  typedef enum logic [1:0] {WAIT_SYNC, FILL, ACC, DUMP} state_t;

  state_t                  state_q;
  logic [CHANNEL_ADDR-1:0] ch_q;
  logic                    err_q;
  logic                    take;
  logic                    last_ch;

  logic [DOUT_WIDTH-1:0]   mem [NCHAN];
  logic [NCHAN-1:0]        ovf_bits_q;
  logic [DOUT_WIDTH-1:0]   rd_q;
  logic                    rd_ovf_q;

  logic                    s1_vld_q;
  logic [CHANNEL_ADDR-1:0] s1_ch_q;
  logic [DIN_WIDTH-1:0]    s1_din_q;
  state_t                  s1_mode_q;

  logic [DOUT_WIDTH-1:0]   din_ext;
  logic [DOUT_WIDTH:0]     sum_w;
  logic [DOUT_WIDTH-1:0]   sum_d;
  logic                    ovf_d;

  logic                    s2_vld_q;
  logic [CHANNEL_ADDR-1:0] s2_ch_q;
  logic [DOUT_WIDTH-1:0]   s2_sum_q;
  logic                    s2_ovf_q;
  logic                    s2_dump_q;
  logic [DOUT_WIDTH-1:0]   s2_old_q;
  logic                    s2_old_ovf_q;

  logic [DOUT_WIDTH-1:0]   dout_q;
  logic [CHANNEL_ADDR-1:0] dout_chan_q;
  logic                    dout_valid_q;
  logic                    ovf_q;

  // A sample is processed only once aligned; sync_in overrides the sample it coincides with.
  assign take    = din_valid && !sync_in && (state_q != WAIT_SYNC);
  assign last_ch = (ch_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SYNC;
      ch_q    <= '0;
      err_q   <= 1'b0;
    end else if (sync_in) begin
      state_q <= FILL;
      ch_q    <= '0;
    end else if (take) begin
      ch_q <= ch_q + CHANNEL_ADDR'(1);
      if (last_ch) begin
        state_q <= new_acc ? DUMP : ACC;
      end else if (new_acc) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read-first block RAM: the read of a channel never meets its own pending write.
  always_ff @(posedge clk) begin
    if (take) begin
      rd_q     <= mem[ch_q];
      rd_ovf_q <= ovf_bits_q[ch_q];
    end
    if (s2_vld_q) begin
      mem[s2_ch_q] <= s2_sum_q;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_vld_q) begin
      ovf_bits_q[s2_ch_q] <= s2_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= take;
      s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      s1_ch_q   <= ch_q;
      s1_din_q  <= din;
      s1_mode_q <= state_q;
    end
  end

  always_comb begin
    din_ext = DOUT_WIDTH'(s1_din_q);
    sum_w   = {1'b0, rd_q} + {1'b0, din_ext};
    sum_d   = din_ext;
    ovf_d   = 1'b0;
    if (s1_mode_q == ACC) begin
      sum_d = sum_w[DOUT_WIDTH] ? '1 : sum_w[DOUT_WIDTH-1:0];
      ovf_d = rd_ovf_q | sum_w[DOUT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (s1_vld_q) begin
      s2_ch_q      <= s1_ch_q;
      s2_sum_q     <= sum_d;
      s2_ovf_q     <= ovf_d;
      s2_dump_q    <= (s1_mode_q == DUMP);
      s2_old_q     <= rd_q;
      s2_old_ovf_q <= rd_ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_chan_q  <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      dout_valid_q <= s2_vld_q && s2_dump_q;
      ovf_q        <= s2_vld_q && s2_dump_q && s2_old_ovf_q;
      if (s2_vld_q && s2_dump_q) begin
        dout_q      <= s2_old_q;
        dout_chan_q <= s2_ch_q;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_chan  = dout_chan_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;
  assign err_align  = err_q;

endmodule

// File: tb/tb_spec_vacc.sv
// Directed and randomized checks of spec_vacc against a queue-based model of
// integrate / dump behaviour with saturation and alignment tracking.
module tb_spec_vacc;

  localparam int unsigned CA = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 8;
  localparam int NCH  = 4;
  localparam int OMAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_in;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          new_acc;
  logic [OW-1:0] dout;
  logic [CA-1:0] dout_chan;
  logic          dout_valid;
  logic          ovf;
  logic          err_align;

  spec_vacc #(
    .CHANNEL_ADDR(CA),
    .DIN_WIDTH   (DW),
    .DOUT_WIDTH  (OW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_in   (sync_in),
    .din       (din),
    .din_valid (din_valid),
    .new_acc   (new_acc),
    .dout      (dout),
    .dout_chan (dout_chan),
    .dout_valid(dout_valid),
    .ovf       (ovf),
    .err_align (err_align)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int ch;
    int data;
    bit ov;
  } exp_t;

  exp_t expq[$];
  int   acc  [NCH];
  bit   satf [NCH];
  bit   m_synced, m_fresh, m_dumping, m_err;
  int   m_ch;
  int   cyc, total, passed, fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d at step %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference: per-channel sums, a fresh-start flag after sync, and a
  // "this spectrum reports the previous integration" flag.
  task automatic model(input bit r, input bit sy, input bit v, input int d, input bit na);
    int s;
    if (r) begin
      m_synced = 0; m_ch = 0; m_err = 0; m_dumping = 0; m_fresh = 0;
      expq.delete();
      return;
    end
    if (sy) begin
      m_synced = 1; m_ch = 0; m_fresh = 1; m_dumping = 0;
      return;
    end
    if (!v || !m_synced) return;
    if (m_dumping) begin
      expq.push_back('{cyc + 2, m_ch, acc[m_ch], satf[m_ch]});
      acc[m_ch] = d; satf[m_ch] = 0;
    end else if (m_fresh) begin
      acc[m_ch] = d; satf[m_ch] = 0;
    end else begin
      s = acc[m_ch] + d;
      if (s > OMAX) begin
        s = OMAX; satf[m_ch] = 1;
      end
      acc[m_ch] = s;
    end
    if (m_ch == NCH - 1) begin
      m_dumping = na;
      m_fresh   = 0;
    end else if (na) begin
      m_err = 1;
    end
    m_ch = (m_ch + 1) % NCH;
  endtask

  task automatic step(input bit r, input bit sy, input bit v, input int d, input bit na);
    bit exp_v;
    rst = r; sync_in = sy; din_valid = v; din = d[DW-1:0]; new_acc = na;
    model(r, sy, v, d, na);
    @(posedge clk);
    #1;
    exp_v = (expq.size() > 0) && (expq[0].due == cyc);
    chk("dout_valid", {31'd0, dout_valid}, {31'd0, exp_v});
    chk("err_align", {31'd0, err_align}, {31'd0, m_err});
    if (r) begin
      chk("rst_dout", 32'(dout), 0);
      chk("rst_dout_chan", 32'(dout_chan), 0);
    end
    if (exp_v) begin
      chk("dout", 32'(dout), expq[0].data);
      chk("dout_chan", 32'(dout_chan), expq[0].ch);
      chk("ovf", {31'd0, ovf}, {31'd0, expq[0].ov});
      void'(expq.pop_front());
    end else begin
      chk("ovf_idle", {31'd0, ovf}, 0);
    end
    cyc++;
  endtask

  // mode 0: constant val, 1: din = ch+1, 2: random. na_ch < 0 means no new_acc.
  task automatic spectrum(input int mode, input int val, input int na_ch, input bit thr);
    int d;
    for (int i = 0; i < NCH; i++) begin
      d = (mode == 0) ? val : (mode == 1) ? i + 1 : int'($urandom_range(0, OMAX));
      step(0, 0, 1, d, i == na_ch);
      if (thr) step(0, 0, 0, int'($urandom_range(0, OMAX)), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, int'($urandom_range(0, OMAX)), 0);
  endtask

  initial begin
    int r;
    bit v, na;
    cyc = 0; total = 0; passed = 0; fails = 0;
    rst = 1; sync_in = 0; din = '0; din_valid = 0; new_acc = 0;
    for (int c = 0; c < NCH; c++) begin
      acc[c] = 0; satf[c] = 0;
    end

    repeat (3) step(1, 0, 0, 0, 0);

    // Unaligned input is discarded, including new_acc and the sample with sync_in.
    for (int i = 0; i < 6; i++) step(0, 0, 1, i + 7, i == 3);
    step(0, 1, 1, 99, 1);

    // Basic: 3-spectrum integration of din = ch+1, then a dump of 3,6,9,12.
    for (int s = 0; s < 6; s++) spectrum(1, 0, (s % 3 == 2) ? NCH - 1 : -1, 0);
    idle(3);

    // Back-to-back dumps.
    step(0, 1, 0, 0, 0);
    for (int s = 0; s < 4; s++) spectrum(1, 0, NCH - 1, 0);
    spectrum(1, 0, -1, 0);
    idle(3);

    // Throttled input, 2-spectrum integration of 10.
    step(0, 1, 0, 0, 0);
    for (int s = 0; s < 4; s++) spectrum(0, 10, (s % 2 == 1) ? NCH - 1 : -1, 1);
    idle(3);

    // Saturation, then a clean integration afterwards.
    step(0, 1, 0, 0, 0);
    spectrum(0, 200, -1, 0);
    spectrum(0, 200, NCH - 1, 0);
    spectrum(0, 1, -1, 0);
    spectrum(0, 1, NCH - 1, 0);
    spectrum(0, 3, -1, 0);
    idle(3);

    // Misaligned new_acc, then a correct one.
    step(0, 1, 0, 0, 0);
    spectrum(2, 0, 1, 0);
    spectrum(2, 0, NCH - 1, 0);
    spectrum(2, 0, -1, 0);
    idle(3);

    // Reset in the middle of a dump; new_acc ignored until the next sync.
    step(0, 1, 0, 0, 0);
    spectrum(2, 0, -1, 0);
    spectrum(2, 0, NCH - 1, 0);
    step(0, 0, 1, 5, 0);
    step(0, 0, 1, 6, 0);
    step(1, 0, 1, 7, 0);
    spectrum(2, 0, NCH - 1, 0);
    spectrum(2, 0, NCH - 1, 0);
    idle(3);

    // sync_in in the middle of ACC drops the partial integration.
    step(0, 1, 0, 0, 0);
    spectrum(0, 50, -1, 0);
    step(0, 0, 1, 50, 0);
    step(0, 0, 1, 50, 0);
    step(0, 1, 1, 50, 0);
    spectrum(1, 0, -1, 0);
    spectrum(1, 0, NCH - 1, 0);
    spectrum(2, 0, -1, 0);
    idle(3);

    // Randomized traffic.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 199));
      v  = ($urandom_range(0, 99) < 75);
      na = v && (m_ch == NCH - 1) && ($urandom_range(0, 2) == 0);
      if (v && m_ch != NCH - 1 && $urandom_range(0, 99) == 0) na = 1;
      if (r < 2)      step(1, 0, v, int'($urandom_range(0, OMAX)), na);
      else if (r < 5) step(0, 1, v, int'($urandom_range(0, OMAX)), na);
      else            step(0, 0, v, int'($urandom_range(0, OMAX)), na);
    end
    idle(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
